// File: rtl/slc3_dp_pkg.sv
// slc3_dp_pkg: shared encodings and helpers for the SLC-3 datapath.
//   - ALUK, PCMUX and ADDR2MUX select encodings
//   - memory access controller state encoding
//   - sext(): sign-extends the low 'bits' bits of an instruction field
package slc3_dp_pkg;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_e;

  typedef enum logic [1:0] {
    PCMUX_INC   = 2'b00,
    PCMUX_BUS   = 2'b01,
    PCMUX_ADDER = 2'b10,
    PCMUX_HOLD  = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2mux_e;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  // Widest datapath the sign-extension helper supports.
  localparam int SEXT_W = 64;

  // Left-align the field so its sign bit lands in the MSB, then
  // arithmetic-shift it back down; 'bits' is a constant at every call site.
  function automatic logic [SEXT_W-1:0] sext(input logic [10:0] field, input int bits);
    logic signed [SEXT_W-1:0] t;
    t = signed'({field, {(SEXT_W-11){1'b0}}}) <<< (11 - bits);
    t = t >>> (SEXT_W - bits);
    return t;
  endfunction

endpackage

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: request/acknowledge memory access controller.
//   state      | meaning
//   MEM_IDLE   | no access outstanding; start launches one
//   MEM_ACCESS | req held high, waiting for ack or timeout
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, we       one-cycle access request and its direction (1 = write)
//   ack             memory completion, honoured only in MEM_ACCESS
//   req, busy       high while an access is outstanding
//   wr              direction of the current/last access
//   done            one-cycle completion pulse (registered)
//   timeout         sticky abort flag, cleared only by reset
//   rd_load         combinational strobe: load read data into MDR this edge
module slc3_mem_ctrl
  import slc3_dp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic we,
  input  logic ack,
  output logic req,
  output logic wr,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic rd_load
);

  // The counter holds the number of ACCESS cycles already spent without ack,
  // so req stays high for exactly MEM_TIMEOUT cycles before an abort.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  mem_state_e state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic wr_nxt, done_nxt, timeout_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MEM_IDLE;
      wait_cnt <= '0;
      wr       <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      wr       <= wr_nxt;
      done     <= done_nxt;
      timeout  <= timeout | timeout_set;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    wr_nxt       = wr;
    done_nxt     = 1'b0;
    timeout_set  = 1'b0;
    rd_load      = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (start) begin
          state_nxt    = MEM_ACCESS;
          wait_cnt_nxt = '0;
          wr_nxt       = we;
        end
      end
      MEM_ACCESS: begin
        // An ack in the final allowed cycle still completes the access.
        if (ack) begin
          state_nxt = MEM_IDLE;
          done_nxt  = 1'b1;
          rd_load   = ~wr;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = MEM_IDLE;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  assign req  = (state == MEM_ACCESS);
  assign busy = (state == MEM_ACCESS);

endmodule

// File: rtl/slc3_datapath_gen.sv
// slc3_datapath_gen: parametrised SLC-3 datapath driven by an external
// control FSM. Holds PC/IR/MAR/MDR, an 8-entry register file, ALU, address
// adder, NZP/BEN, a registered LED latch and a req/ack memory port.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   LD_*                       register load enables
//   Gate*                      bus driver enables
//   SR2MUX..ALUK               datapath mux selects
//   Mem_Start, Mem_WE          launch a memory access at MAR (read/write)
//   Mem_Rdata, Mem_Ack         memory response
//   Mem_Req, Mem_Wr, Mem_Addr, Mem_Wdata, Mem_Busy, Mem_Done, Mem_Timeout
//   PC, IR, MAR, MDR, NZP, BEN, LED, Bus_Err
// Build option SLC3_BUS_CHECK_EN: when defined, more than one asserted gate
// forces the bus to zero and sets the sticky Bus_Err flag; otherwise gates
// resolve by fixed priority ALU > MARMUX > PC > MDR and Bus_Err is 0.
module slc3_datapath_gen
  import slc3_dp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LED_W       = 10,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic [1:0]       PCMUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             Mem_Start,
  input  logic             Mem_WE,
  input  logic [WIDTH-1:0] Mem_Rdata,
  input  logic             Mem_Ack,
  output logic             Mem_Req,
  output logic             Mem_Wr,
  output logic [WIDTH-1:0] Mem_Addr,
  output logic [WIDTH-1:0] Mem_Wdata,
  output logic             Mem_Busy,
  output logic             Mem_Done,
  output logic             Mem_Timeout,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [2:0]       NZP,
  output logic             BEN,
  output logic [LED_W-1:0] LED,
  output logic             Bus_Err
);

  logic [WIDTH-1:0] regs [8];
  logic [2:0]       dr, sr1, sr2;
  logic [WIDTH-1:0] sr1_out, sr2_out, alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder, bus, pc_next;
  logic [SEXT_W-1:0] sx5, sx6, sx9, sx11;
  logic [WIDTH-1:0] imm5, off6, off9, off11;
  logic             mem_rd_load;

  assign sx5   = sext({6'b0, IR[4:0]}, 5);
  assign sx6   = sext({5'b0, IR[5:0]}, 6);
  assign sx9   = sext({2'b0, IR[8:0]}, 9);
  assign sx11  = sext(IR[10:0], 11);
  assign imm5  = sx5[WIDTH-1:0];
  assign off6  = sx6[WIDTH-1:0];
  assign off9  = sx9[WIDTH-1:0];
  assign off11 = sx11[WIDTH-1:0];

  // Upper sign-extension bits beyond WIDTH are intentionally discarded.
  logic unused_sext;
  assign unused_sext = ^{sx5, sx6, sx9, sx11};

  assign dr  = DRMUX ? 3'b111 : IR[11:9];
  assign sr1 = SR1MUX ? IR[8:6] : IR[11:9];
  assign sr2 = IR[2:0];
  assign sr1_out = regs[sr1];
  assign sr2_out = regs[sr2];

  assign alu_b = SR2MUX ? imm5 : sr2_out;

  always_comb begin
    alu_out = sr1_out;
    case (aluk_e'(ALUK))
      ALUK_ADD:  alu_out = sr1_out + alu_b;
      ALUK_AND:  alu_out = sr1_out & alu_b;
      ALUK_NOT:  alu_out = ~sr1_out;
      ALUK_PASS: alu_out = sr1_out;
      default:   alu_out = sr1_out;
    endcase
  end

  assign addr1 = ADDR1MUX ? sr1_out : PC;

  always_comb begin
    addr2 = '0;
    case (addr2mux_e'(ADDR2MUX))
      ADDR2_ZERO:  addr2 = '0;
      ADDR2_OFF6:  addr2 = off6;
      ADDR2_OFF9:  addr2 = off9;
      ADDR2_OFF11: addr2 = off11;
      default:     addr2 = '0;
    endcase
  end

  assign adder = addr1 + addr2;

`ifdef SLC3_BUS_CHECK_EN
  logic [3:0] gates;
  logic       gate_conflict;
  logic       bus_err_q;

  assign gates = {GateALU, GateMARMUX, GatePC, GateMDR};
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign gate_conflict = (gates & (gates - 4'd1)) != 4'd0;

  always_comb begin
    bus = '0;
    if (!gate_conflict) begin
      if (GateALU)         bus = alu_out;
      else if (GateMARMUX) bus = adder;
      else if (GatePC)     bus = PC;
      else if (GateMDR)    bus = MDR;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)              bus_err_q <= 1'b0;
    else if (gate_conflict) bus_err_q <= 1'b1;
  end

  assign Bus_Err = bus_err_q;
`else
  always_comb begin
    bus = '0;
    if (GateALU)         bus = alu_out;
    else if (GateMARMUX) bus = adder;
    else if (GatePC)     bus = PC;
    else if (GateMDR)    bus = MDR;
  end

  assign Bus_Err = 1'b0;
`endif

  always_comb begin
    pc_next = PC;
    case (pcmux_e'(PCMUX))
      PCMUX_INC:   pc_next = PC + 1'b1;
      PCMUX_BUS:   pc_next = bus;
      PCMUX_ADDER: pc_next = adder;
      PCMUX_HOLD:  pc_next = PC;
      default:     pc_next = PC;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC  <= '0;
      IR  <= '0;
      MAR <= '0;
      MDR <= '0;
      NZP <= 3'b010;
      BEN <= 1'b0;
      LED <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (LD_PC)  PC  <= pc_next;
      if (LD_IR)  IR  <= bus;
      if (LD_MAR) MAR <= bus;
      // A read completion takes precedence over a bus load in the same cycle.
      if (mem_rd_load)  MDR <= Mem_Rdata;
      else if (LD_MDR)  MDR <= bus;
      if (LD_CC) begin
        if (bus[WIDTH-1])    NZP <= 3'b100;
        else if (bus == '0)  NZP <= 3'b010;
        else                 NZP <= 3'b001;
      end
      if (LD_BEN) BEN <= |(IR[11:9] & NZP);
      if (LD_LED) LED <= IR[LED_W-1:0];
      if (LD_REG) regs[dr] <= bus;
    end
  end

  slc3_mem_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_ctrl (
    .clk     (Clk),
    .reset   (Reset),
    .start   (Mem_Start),
    .we      (Mem_WE),
    .ack     (Mem_Ack),
    .req     (Mem_Req),
    .wr      (Mem_Wr),
    .busy    (Mem_Busy),
    .done    (Mem_Done),
    .timeout (Mem_Timeout),
    .rd_load (mem_rd_load)
  );

  assign Mem_Addr  = MAR;
  assign Mem_Wdata = MDR;

endmodule

// File: doc/slc3_datapath_gen.md
# slc3_datapath_gen

Parametrised next-generation SLC-3 datapath: WIDTH-bit PC/IR/MAR/MDR/register file, ALU, address adder, NZP condition codes and BEN, driven by the external control FSM through the same load/gate/mux signals as before. Adds a request/acknowledge memory port with a wait-state-tolerant access controller and timeout, a registered LED latch, and optional bus-contention checking. Sits between the control FSM and the memory/IO subsystem.

## Interface
- WIDTH, 16, datapath width; must be ≥16 (LC-3 instruction fields fixed at bits 15:0)
- LED_W, 10, LED latch width; ≤WIDTH
- MEM_TIMEOUT, 255, max wait cycles for Mem_Ack before abort; ≥1
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers
- SR2MUX, ADDR1MUX, DRMUX, SR1MUX  in  1 each;  PCMUX, ADDR2MUX, ALUK  in  2 each  mux selects
- Mem_Start  in  1  one-cycle request to begin access at MAR
- Mem_WE  in  1  sampled with Mem_Start: 1 write MDR, 0 read into MDR
- Mem_Rdata  in  WIDTH  read data, valid with Mem_Ack
- Mem_Ack  in  1  memory completion
- Mem_Req  out  1  held high while access outstanding
- Mem_Wr  out  1  direction of outstanding access
- Mem_Addr  out  WIDTH  = MAR;  Mem_Wdata  out  WIDTH  = MDR
- Mem_Busy  out  1  controller not IDLE;  Mem_Done  out  1  one-cycle completion pulse
- Mem_Timeout  out  1  sticky abort flag
- PC, IR, MAR, MDR  out  WIDTH  architectural registers
- NZP  out  3;  BEN  out  1;  LED  out  LED_W;  Bus_Err  out  1

## Operation
- Bus: one-hot {GateALU,GateMARMUX,GatePC,GateMDR} selects ALU_out/Adder/PC/MDR; none asserted → 0.
- PCMUX: 00 PC+1, 01 Bus, 10 Adder, 11 hold PC. Arithmetic modulo 2^WIDTH.
- Adder = ADDR1 + ADDR2; ADDR1MUX 0 PC, 1 SR1_OUT; ADDR2MUX 00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 sext(IR[10:0]); sign extension to WIDTH.
- Register file 8×WIDTH; DR = DRMUX ? 3'b111 : IR[11:9]; SR1 = SR1MUX ? IR[8:6] : IR[11:9]; SR2 = IR[2:0]; write Bus on LD_REG; combinational read (read-before-write same cycle).
- ALU B = SR2MUX ? sext(IR[4:0]) : SR2_OUT; ALUK 00 A+B, 01 A&B, 10 ~A, 11 A.
- LD_CC: N=Bus[WIDTH-1], Z=(Bus==0), P=otherwise; exactly one set.
- LD_BEN: BEN ← |(IR[11:9] & NZP) using current NZP.
- LD_LED: LED ← IR[LED_W-1:0]; registered.
- MDR load: LD_MDR ← Bus; memory read completion ← Mem_Rdata; completion wins if same cycle.
- Memory controller states: IDLE, ACCESS. IDLE + Mem_Start → ACCESS, Mem_Wr ← Mem_WE, wait counter ← 0. ACCESS: Mem_Req=1; Mem_Ack → IDLE, Mem_Done=1, read loads MDR. Counter reaching MEM_TIMEOUT without Ack → IDLE, Mem_Timeout←1, no Done, MDR unchanged. Mem_Start while busy ignored. Ack in IDLE ignored.
- Mem_Timeout cleared only by Reset.

## Timing
- Reset values: PC, IR, MAR, MDR, regs, LED = 0; NZP=3'b010; BEN=0; controller IDLE; Mem_Req, Mem_Busy, Mem_Done, Mem_Timeout, Bus_Err = 0.
- All loads take effect at the edge where load asserted; outputs visible next cycle.
- Mem_Req rises cycle after Mem_Start; zero-wait Ack in that cycle → Mem_Done and MDR update next cycle (2-cycle min access).
- Timeout: Ack absent for MEM_TIMEOUT cycles of Mem_Req → abort on following edge.
- Reset mid-access: immediate return to IDLE, Mem_Req low next cycle.

## Configuration
- SLC3_BUS_CHECK_EN defined: >1 gate asserted → Bus=0 and Bus_Err set sticky until Reset.
- Undefined: fixed priority GateALU > GateMARMUX > GatePC > GateMDR; Bus_Err tied 0.

## Structure
- Package slc3_dp_pkg: ALUK, PCMUX, ADDR2MUX encodings as enums; memory controller state enum; sext function.
- Sub-module slc3_mem_ctrl: controller FSM, wait counter, Mem_Done/Mem_Timeout.

## Test plan
- Reset, LD_PC with PCMUX=00 three cycles → PC=3; PCMUX=11 → PC holds 3.
- R1=5, IR=0x1261 (ADD R1,R1,#1), GateALU+LD_REG+LD_CC → R1=6, NZP=001; ADD #-7 → R1=0xFFFF, NZP=100.
- MAR=0x0030, Mem_Start read, Ack after 3 waits with Rdata=0xBEEF → MDR=0xBEEF, one Mem_Done pulse, Mem_Req high exactly 4 cycles.
- MEM_TIMEOUT=4, no Ack → Mem_Req drops after 4 cycles, Mem_Timeout=1, Mem_Done never, MDR unchanged; Mem_Start during access ignored.
- IR=0x0402 (BRz), NZP=010, LD_BEN → BEN=1; NZP=001 → BEN=0.
- GatePC+GateMDR together: with macro Bus=0, Bus_Err=1 sticky; without, Bus=PC, Bus_Err=0.
